// File: rtl/hamming_pkg.sv
// Shared definitions for the 11-bit Hamming (7 data bits) encoder/decoder pair.
// Bit index i corresponds to Hamming position 11 - i.
package hamming_pkg;

  localparam int CODE_W = 11;
  localparam int DATA_W = 7;
  localparam int SYN_W  = 4;

  // Code-word bit indices of the data bits, listed MSB of the data word first.
  localparam int DATA_IDX [DATA_W] = '{8, 6, 5, 4, 2, 1, 0};

  typedef enum logic [1:0] {
    NONE,
    CORRECTED,
    UNCORRECTABLE
  } err_class_e;

  // Code-word bit index addressed by a correctable syndrome (1..11).
  function automatic logic [SYN_W-1:0] syn2bit(input logic [SYN_W-1:0] s);
    return SYN_W'(CODE_W) - s;
  endfunction

  function automatic err_class_e classify(input logic [SYN_W-1:0] s);
    if (s == '0) begin
      return NONE;
    end else if (s <= SYN_W'(CODE_W)) begin
      return CORRECTED;
    end else begin
      return UNCORRECTABLE;
    end
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome {s8, s4, s2, s1} of an 11-bit Hamming code word.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syndrome
);

  assign syndrome[0] = code[10] ^ code[8] ^ code[6] ^ code[4] ^ code[2] ^ code[0];
  assign syndrome[1] = code[9]  ^ code[8] ^ code[5] ^ code[4] ^ code[1] ^ code[0];
  assign syndrome[2] = code[7]  ^ code[6] ^ code[5] ^ code[4];
  assign syndrome[3] = code[3]  ^ code[2] ^ code[1] ^ code[0];

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage streaming SEC Hamming decoder with valid/ready handshake and
// saturating corrected/uncorrectable word counters.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [SYN_W-1:0]    out_syndrome,
  output logic                out_corrected,
  output logic                out_uncorrectable,
  input  logic                clr_counts,
  output logic [CNT_W-1:0]    corr_count,
  output logic [CNT_W-1:0]    uncorr_count
);

  logic                s1_valid_reg;
  logic [CODE_W-1:0]   s1_code_reg;
  logic [SYN_W-1:0]    s1_syn_reg;

  logic                s2_valid_reg;
  logic [DATA_W-1:0]   s2_data_reg;
  logic [SYN_W-1:0]    s2_syn_reg;
  logic                s2_corr_reg;
  logic                s2_uncorr_reg;

  logic [CNT_W-1:0]    corr_count_reg;
  logic [CNT_W-1:0]    corr_count_next;
  logic [CNT_W-1:0]    uncorr_count_reg;
  logic [CNT_W-1:0]    uncorr_count_next;

  logic [SYN_W-1:0]    in_syn;
  err_class_e          s1_class;
  logic [SYN_W-1:0]    s1_flip_idx;
  logic [CODE_W-1:0]   flip_mask;
  logic [CODE_W-1:0]   fixed_code;
  logic [DATA_W-1:0]   fixed_data;

  logic                s1_adv;
  logic                s2_adv;
  logic                out_fire;

  hamming_syndrome u_syndrome (
    .code     (in_code),
    .syndrome (in_syn)
  );

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = s2_valid_reg && out_ready;

  assign s1_class    = classify(s1_syn_reg);
  assign s1_flip_idx = syn2bit(s1_syn_reg);

  generate
    for (genvar gi = 0; gi < CODE_W; gi++) begin : g_flip
      assign flip_mask[gi] = (s1_class == CORRECTED) && (s1_flip_idx == SYN_W'(gi));
    end
  endgenerate

  assign fixed_code = s1_code_reg ^ flip_mask;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
      assign fixed_data[gi] = fixed_code[DATA_IDX[DATA_W-1-gi]];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_code_reg  <= '0;
      s1_syn_reg   <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_code_reg <= in_code;
        s1_syn_reg  <= in_syn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg  <= 1'b0;
      s2_data_reg   <= '0;
      s2_syn_reg    <= '0;
      s2_corr_reg   <= 1'b0;
      s2_uncorr_reg <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg   <= fixed_data;
        s2_syn_reg    <= s1_syn_reg;
        s2_corr_reg   <= (s1_class == CORRECTED);
        s2_uncorr_reg <= (s1_class == UNCORRECTABLE);
      end
    end
  end

  // Clear beats a same-cycle increment; counts stick at all-ones.
  always_comb begin
    corr_count_next   = corr_count_reg;
    uncorr_count_next = uncorr_count_reg;
    if (clr_counts) begin
      corr_count_next   = '0;
      uncorr_count_next = '0;
    end else if (out_fire) begin
      if (s2_corr_reg && !(&corr_count_reg)) begin
        corr_count_next = corr_count_reg + 1'b1;
      end
      if (s2_uncorr_reg && !(&uncorr_count_reg)) begin
        uncorr_count_next = uncorr_count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_count_reg   <= '0;
      uncorr_count_reg <= '0;
    end else begin
      corr_count_reg   <= corr_count_next;
      uncorr_count_reg <= uncorr_count_next;
    end
  end

  assign out_valid         = s2_valid_reg;
  assign out_data          = s2_data_reg;
  assign out_syndrome      = s2_syn_reg;
  assign out_corrected     = s2_corr_reg;
  assign out_uncorrectable = s2_uncorr_reg;
  assign corr_count        = corr_count_reg;
  assign uncorr_count      = uncorr_count_reg;

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_hamming_decoder;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [10:0]      in_code;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_data;
  logic [3:0]       out_syndrome;
  logic             out_corrected;
  logic             out_uncorrectable;
  logic             clr_counts;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_code           (in_code),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_syndrome      (out_syndrome),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .clr_counts        (clr_counts),
    .corr_count        (corr_count),
    .uncorr_count      (uncorr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] data;
    logic [3:0] syn;
    logic       corr;
    logic       uncorr;
    int         acc_cyc;
    bit         chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic exp_t mk(input logic [6:0] d, input logic [3:0] s, input logic c, input logic u);
    exp_t e;
    e.data = d; e.syn = s; e.corr = c; e.uncorr = u; e.acc_cyc = 0; e.chk_lat = 1'b0;
    return e;
  endfunction

  // Reference decode: syndrome is the XOR of the Hamming positions of all set bits.
  function automatic exp_t ref_decode(input logic [10:0] code);
    logic [3:0]  s;
    logic [10:0] f;
    s = '0;
    for (int i = 0; i < 11; i++) if (code[i]) s ^= 4'(11 - i);
    f = code;
    if (s >= 1 && s <= 11) f[11 - int'(s)] = ~f[11 - int'(s)];
    return mk({f[8], f[6], f[5], f[4], f[2], f[1], f[0]}, s,
              (s >= 1 && s <= 11), (s >= 12));
  endfunction

  function automatic logic [10:0] encode(input logic [6:0] d);
    logic [10:0] c;
    c = '0;
    {c[8], c[6], c[5], c[4], c[2], c[1], c[0]} = d;
    c[10] = c[8] ^ c[6] ^ c[4] ^ c[2] ^ c[0];
    c[9]  = c[8] ^ c[5] ^ c[4] ^ c[1] ^ c[0];
    c[7]  = c[6] ^ c[5] ^ c[4];
    c[3]  = c[2] ^ c[1] ^ c[0];
    return c;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [10:0] code, input exp_t e, input bit chk_lat);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_code  = code;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) break;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      e.acc_cyc = cyc;
      e.chk_lat = chk_lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshake comparison, output stability, in_ready and counter models.
  initial begin : monitor
    int         in_flight;
    int         m_corr;
    int         m_uncorr;
    bit         prev_stall;
    logic [6:0] p_data;
    logic [3:0] p_syn;
    logic       p_corr;
    logic       p_uncorr;
    exp_t       e;
    in_flight = 0; m_corr = 0; m_uncorr = 0; prev_stall = 1'b0;
    p_data = '0; p_syn = '0; p_corr = 1'b0; p_uncorr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        in_flight = 0; m_corr = 0; m_uncorr = 0; prev_stall = 1'b0;
      end else begin
        check("corr_count", corr_count, m_corr);
        check("uncorr_count", uncorr_count, m_uncorr);
        check("in_ready", in_ready, !(in_flight == 2 && !out_ready));
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, p_data);
          check("stall_syn", out_syndrome, p_syn);
          check("stall_flags", {out_corrected, out_uncorrectable}, {p_corr, p_uncorr});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_syndrome", out_syndrome, e.syn);
            check("out_corrected", out_corrected, e.corr);
            check("out_uncorrectable", out_uncorrectable, e.uncorr);
            if (e.chk_lat) check("latency", cyc - e.acc_cyc, 2);
            if (!clr_counts) begin
              if (e.corr && m_corr < CNT_MAX) m_corr++;
              if (e.uncorr && m_uncorr < CNT_MAX) m_uncorr++;
            end
          end
          in_flight--;
        end
        if (clr_counts) begin
          m_corr = 0;
          m_uncorr = 0;
        end
        if (in_valid && in_ready) in_flight++;
        prev_stall = out_valid && !out_ready;
        p_data = out_data; p_syn = out_syndrome;
        p_corr = out_corrected; p_uncorr = out_uncorrectable;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [6:0]  d;
    logic [10:0] c;
    logic [10:0] rc;
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clr_counts = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_syndrome", out_syndrome, 0);
    check("rst_flags", {out_corrected, out_uncorrectable}, 0);
    check("rst_counts", {corr_count, uncorr_count}, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed hand-computed vectors
    send(11'h539, mk(7'h59, 4'h0, 1'b0, 1'b0), 1'b1);
    send(11'h519, mk(7'h59, 4'h6, 1'b1, 1'b0), 1'b1);
    send(11'h531, mk(7'h59, 4'h8, 1'b1, 1'b0), 1'b1);
    send(11'h5B1, mk(7'h59, 4'hC, 1'b0, 1'b1), 1'b1);
    drain();
    check("corr_after_directed", corr_count, 2);
    check("uncorr_after_directed", uncorr_count, 1);

    // Single-bit-flip sweep over random data words
    for (int k = 0; k < 4; k++) begin
      d = 7'($urandom);
      c = encode(d);
      send(c, mk(d, 4'h0, 1'b0, 1'b0), 1'b1);
      for (int b = 0; b < 11; b++) begin
        send(c ^ (11'd1 << b), mk(d, 4'(11 - b), 1'b1, 1'b0), 1'b1);
      end
    end
    drain();
    check("corr_saturated", corr_count, 4'hF);

    // Plain clear, then clear coinciding with a corrected-word delivery
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    for (int k = 0; k < 3; k++) send(11'h519, mk(7'h59, 4'h6, 1'b1, 1'b0), 1'b1);
    drain();
    check("corr_after_clear", corr_count, 3);
    out_ready = 1'b0;
    send(11'h531, mk(7'h59, 4'h8, 1'b1, 1'b0), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("held_valid", out_valid, 1);
    clr_counts = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    check("clr_beats_inc", corr_count, 0);
    drain();

    // Random backpressure stream
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rc = 11'($urandom);
      send(rc, ref_decode(rc), 1'b0);
    end
    drain();
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b0;

    // Reset with both stages full
    send(11'h5B1, mk(7'h59, 4'hC, 1'b0, 1'b1), 1'b0);
    send(11'h539, mk(7'h59, 4'h0, 1'b0, 1'b0), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_counts", {corr_count, uncorr_count}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_stale", out_valid, 0);
    end
    send(11'h539, mk(7'h59, 4'h0, 1'b0, 1'b0), 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Streaming single-error-correcting decoder for the 11-bit Hamming code words produced by the team's `hamming_encoder`. It accepts one code word per cycle over a valid/ready handshake and computes the 4-bit syndrome. It corrects any single-bit error and recovers the 7 data bits, flagging syndromes that cannot be corrected. It sits at the receive side of the link and returns 7-bit parts to the downstream consumer, with saturating error counters for link monitoring.

## Interface
Parameters:
- `CNT_W`, 16, width of each saturating error counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  code word present
- `in_ready`  out  1  decoder accepts the word this cycle
- `in_code`  in  11  code word; bit layout per the encoder (parity at bits 10, 9, 7, 3; data at bits 8, 6, 5, 4, 2, 1, 0)
- `out_valid`  out  1  decoded result present
- `out_ready`  in  1  consumer accepts the result
- `out_data`  out  7  recovered data: {b8, b6, b5, b4, b2, b1, b0} of the corrected word
- `out_syndrome`  out  4  {s8, s4, s2, s1}
- `out_corrected`  out  1  a single-bit error was corrected (including parity-bit errors)
- `out_uncorrectable`  out  1  syndrome 12..15; data passed uncorrected
- `clr_counts`  in  1  synchronous clear of both counters
- `corr_count`  out  CNT_W  saturating count of corrected words delivered
- `uncorr_count`  out  CNT_W  saturating count of uncorrectable words delivered

## Operation
- Hamming position p = 11 − bit index (bit 10 is p1, bit 0 is p11).
- Syndrome bits:
  - s1 = b10^b8^b6^b4^b2^b0
  - s2 = b9^b8^b5^b4^b1^b0
  - s4 = b7^b6^b5^b4
  - s8 = b3^b2^b1^b0
- Syndrome S = 0: no error; data passed through; both flags 0.
- S = 1..11: flip bit (11 − S); `out_corrected`=1.
- S = 12..15: no flip; `out_uncorrectable`=1; data is raw.
- Double errors whose syndrome falls in 1..11 are miscorrected. This is the documented SEC-only limitation; no DED.
- Pipeline:
  - Stage 1 registers the code word and the syndrome.
  - Stage 2 registers the corrected data, the flags and the syndrome.
  - Each stage has its own valid bit.
- Counters increment only on an output handshake (`out_valid && out_ready`) with the matching flag set. They hold at all-ones.
- `clr_counts` takes priority over an increment in the same cycle.

## Timing
- Latency: a word accepted in cycle N appears on `out_*` in cycle N+2 when there is no backpressure. Throughput is 1 word per cycle.
- Stage advance:
  - `s2_adv` = !s2_valid || out_ready
  - `s1_adv` = !s1_valid || s2_adv
  - `in_ready` = `s1_adv`, combinational from `out_ready`, with no combinational path from `in_valid`.
- While `out_valid`=1 and `out_ready`=0, every `out_*` value stays stable. No word is dropped or duplicated.
- Simultaneous input accept and output drain in one cycle sustain full rate.
- Reset (asynchronous, any time including mid-stream):
  - Both valid bits go to 0, so `out_valid`=0 and `in_ready`=1 after reset.
  - `out_data`, `out_syndrome` and both flags are 0.
  - Both counters are 0.
  - In-flight words are discarded.
- Data registers need not be reset functionally, but they are reset to 0 so output values are deterministic.

## Structure
- Shared package `hamming_pkg` holds:
  - constants: `CODE_W`=11, `DATA_W`=7, `SYN_W`=4
  - the data-bit index list {8, 6, 5, 4, 2, 1, 0}
  - a function `syn2bit(S)` returning the bit index to flip
  - an enum for the error class: NONE, CORRECTED, UNCORRECTABLE
- The encoder migrates to the same package.
- One sub-module, `hamming_syndrome`, is natural: a combinational 11-bit word to 4-bit syndrome function, reused by the encoder's self-check bench.
- The pipeline registers, the handshake and the counters live in `hamming_decoder`.

## Test plan
- Clean word: `in_code`=11'h539 → `out_data`=7'h59, syndrome 0, both flags 0, appearing 2 cycles after accept.
- Single data error: 11'h519 (bit 5 flipped) → `out_data`=7'h59, syndrome 4'h6, `out_corrected`=1, `corr_count` increments by 1.
- Parity error plus sweep:
  - 11'h531 (bit 3 flipped) → syndrome 4'h8, data 7'h59, `out_corrected`=1.
  - Sweep all 11 single-bit flips of random words → data always restored.
- Uncorrectable: 11'h5B1 (bits 7 and 3 flipped) → syndrome 4'hC, `out_uncorrectable`=1, `out_data`=7'h59, `uncorr_count` increments.
- Backpressure:
  - Stream 20 words with random `out_ready` (50%) → in-order delivery, no loss, outputs stable while stalled.
  - `in_ready` is 0 only when both stages are full and `out_ready`=0.
- Counters and reset:
  - With `CNT_W`=4, deliver 20 corrected words → `corr_count` saturates at 4'hF.
  - `clr_counts` with a simultaneous increment → counter is 0.
  - Assert `rst_n` low with both stages full → `out_valid` drops immediately; no stale word after release.
